// File: rtl/riscv_pipe_stage_pkg.sv
// riscv_pipe_stage_pkg: shared pipeline-stage widths, ctrl-field layout, NOP encoding and stage occupancy states
package riscv_pipe_stage_pkg;
  localparam int CTRL_W_DEF = 12;
  localparam int DATA_W_DEF = 192;
  localparam int CNT_W_DEF  = 16;
  localparam int REGWRITE_B   = 0;
  localparam int RESULTSRC_B  = 1;
  localparam int MEMWRITE_B   = 3;
  localparam int JUMP_B       = 4;
  localparam int BRANCH_B     = 5;
  localparam int ALUCTRL_B    = 6;
  localparam int ALUSRC_B     = 9;
  localparam int ALUSRCASEL_B = 10;
  localparam logic [CTRL_W_DEF-1:0] CTRL_NOP = '0;
  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_e;
  function automatic state_e occ_state(logic main_v, logic skid_v);
    return skid_v ? ST_FULL : (main_v ? ST_ONE : ST_EMPTY);
  endfunction
endpackage

// File: rtl/riscv_pipe_stage_slot.sv
// riscv_pipe_stage_slot: one valid+ctrl+data register; flush beats load beats clear
module riscv_pipe_stage_slot
  import riscv_pipe_stage_pkg::*;
#(
  parameter int CTRL_W         = CTRL_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter bit FLUSH_CLR_DATA = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic              i_flush,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data
);
  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data;
  // Clearing only kills valid and ctrl; data stays visible for hazard checks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_data  <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      if (FLUSH_CLR_DATA) r_data <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_ctrl  <= i_ctrl;
      r_data  <= i_data;
    end else if (i_clear) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end
  end
  assign o_valid = r_valid;
  assign o_ctrl  = r_ctrl;
  assign o_data  = r_data;
endmodule

// File: rtl/riscv_pipe_stage.sv
// riscv_pipe_stage: valid/ready pipeline register with optional skid slot, legacy stall/flush and event counters
module riscv_pipe_stage
  import riscv_pipe_stage_pkg::*;
#(
  parameter int CTRL_W         = CTRL_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter bit SKID           = 1'b1,
  parameter bit FLUSH_CLR_DATA = 1'b0,
  parameter int CNT_W          = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [CTRL_W-1:0] i_in_ctrl,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [CTRL_W-1:0] o_out_ctrl,
  output logic [DATA_W-1:0] o_out_data,
  input  logic              i_stall,
  input  logic              i_flush,
  output logic [1:0]        o_occupancy,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [CNT_W-1:0]  o_flush_cnt
);
  logic              w_main_v, w_skid_v, w_take, w_put, w_in_ready;
  logic              w_main_load, w_main_clear, w_skid_load, w_skid_clear;
  logic [CTRL_W-1:0] w_skid_ctrl;
  logic [DATA_W-1:0] w_skid_data;
  state_e            w_state;
  logic [CNT_W-1:0]  r_stall_cnt, r_flush_cnt;
  assign w_state    = occ_state(w_main_v, w_skid_v);
  assign w_take     = w_main_v & i_out_ready & ~i_stall;
  // With a skid slot in_ready depends only on registered state, never on out_ready
  assign w_in_ready = SKID ? rst_n & ~w_skid_v & ~i_stall
                           : rst_n & (~w_main_v | i_out_ready) & ~i_stall;
  assign w_put        = i_in_valid & w_in_ready;
  assign w_main_load  = (w_state == ST_FULL) ? w_take : w_put & ((w_state == ST_EMPTY) | w_take);
  assign w_main_clear = w_take & ~w_main_load;
  assign w_skid_load  = w_put & (w_state == ST_ONE) & ~w_take;
  assign w_skid_clear = (w_state == ST_FULL) & w_take;
  riscv_pipe_stage_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .FLUSH_CLR_DATA(FLUSH_CLR_DATA)) u_main (
    .clk(clk), .rst_n(rst_n), .i_load(w_main_load), .i_clear(w_main_clear), .i_flush(i_flush),
    .i_ctrl(w_skid_v ? w_skid_ctrl : i_in_ctrl), .i_data(w_skid_v ? w_skid_data : i_in_data),
    .o_valid(w_main_v), .o_ctrl(o_out_ctrl), .o_data(o_out_data)
  );
  generate
    if (SKID) begin : g_skid
      riscv_pipe_stage_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .FLUSH_CLR_DATA(FLUSH_CLR_DATA)) u_skid (
        .clk(clk), .rst_n(rst_n), .i_load(w_skid_load), .i_clear(w_skid_clear), .i_flush(i_flush),
        .i_ctrl(i_in_ctrl), .i_data(i_in_data),
        .o_valid(w_skid_v), .o_ctrl(w_skid_ctrl), .o_data(w_skid_data)
      );
    end else begin : g_no_skid
      assign w_skid_v    = 1'b0;
      assign w_skid_ctrl = '0;
      assign w_skid_data = '0;
    end
  endgenerate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (i_stall & w_main_v & (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (i_flush & (w_main_v | w_skid_v | i_in_valid) & (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end
  assign o_in_ready  = w_in_ready;
  assign o_out_valid = w_main_v;
  assign o_occupancy = 2'(w_main_v) + 2'(w_skid_v);
  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;
endmodule

// File: tb/tb_riscv_pipe_stage.sv
// tb_riscv_pipe_stage: directed vector table for the skid build plus hand sequences for reset and the no-skid build
module tb_riscv_pipe_stage;
  localparam logic [11:0] C = 12'h0A5;
  logic clk = 1'b0, rst_n = 1'b1;
  always #5 clk = ~clk;
  logic a_v = 0, a_or = 0, a_st = 0, a_fl = 0;
  logic [31:0] a_d = 0;
  logic a_ir, a_ov;
  logic [11:0] a_c;
  logic [31:0] a_q;
  logic [1:0] a_occ;
  logic [15:0] a_sc, a_fc;
  logic b_v = 0, b_or = 0, b_st = 0, b_fl = 0;
  logic [31:0] b_d = 0;
  logic b_ir, b_ov;
  logic [11:0] b_c;
  logic [31:0] b_q;
  logic [1:0] b_occ, b_sc, b_fc;
  int n_cmp = 0, n_bad = 0;
  riscv_pipe_stage #(.CTRL_W(12), .DATA_W(32), .SKID(1'b1), .FLUSH_CLR_DATA(1'b0), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .i_in_valid(a_v), .o_in_ready(a_ir), .i_in_ctrl(C), .i_in_data(a_d),
    .o_out_valid(a_ov), .i_out_ready(a_or), .o_out_ctrl(a_c), .o_out_data(a_q),
    .i_stall(a_st), .i_flush(a_fl), .o_occupancy(a_occ), .o_stall_cnt(a_sc), .o_flush_cnt(a_fc));
  riscv_pipe_stage #(.CTRL_W(12), .DATA_W(32), .SKID(1'b0), .FLUSH_CLR_DATA(1'b0), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_in_valid(b_v), .o_in_ready(b_ir), .i_in_ctrl(C), .i_in_data(b_d),
    .o_out_valid(b_ov), .i_out_ready(b_or), .o_out_ctrl(b_c), .o_out_data(b_q),
    .i_stall(b_st), .i_flush(b_fl), .o_occupancy(b_occ), .o_stall_cnt(b_sc), .o_flush_cnt(b_fc));
  typedef struct {
    logic v; logic [31:0] d; logic o_r, st, fl;
    logic e_ir, e_ov; logic [31:0] e_d; logic [1:0] e_occ; logic [15:0] e_sc, e_fc;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t mk(logic v, logic [31:0] d, logic o_r, logic st, logic fl,
                              logic ir, logic ov, logic [31:0] ed, logic [1:0] occ, logic [15:0] sc, logic [15:0] fc);
    vec_t t;
    t.v = v; t.d = d; t.o_r = o_r; t.st = st; t.fl = fl;
    t.e_ir = ir; t.e_ov = ov; t.e_d = ed; t.e_occ = occ; t.e_sc = sc; t.e_fc = fc;
    return t;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic b_step(input string name, input logic v, input logic [31:0] d, input logic o_r, input logic st,
                        input logic ir, input logic ov, input logic [31:0] ed, input logic [1:0] sc);
    @(negedge clk);
    b_v = v; b_d = d; b_or = o_r; b_st = st;
    #1 chk({name, ".in_ready"}, 64'(b_ir), 64'(ir));
    @(posedge clk);
    #1;
    chk({name, ".out_valid"}, 64'(b_ov), 64'(ov));
    chk({name, ".out_ctrl"}, 64'(b_c), ov ? 64'(C) : 64'd0);
    chk({name, ".out_data"}, 64'(b_q), 64'(ed));
    chk({name, ".occupancy"}, 64'(b_occ), 64'(ov));
    chk({name, ".stall_cnt"}, 64'(b_sc), 64'(sc));
  endtask
  initial begin
    for (int i = 1; i <= 8; i++) tbl.push_back(mk(1, i, 1, 0, 0, 1, 1, i, 1, 0, 0));
    tbl.push_back(mk(0, 0,     1, 0, 0, 1, 0, 8,     0, 0, 0));
    tbl.push_back(mk(1, 'h11,  0, 0, 0, 1, 1, 'h11,  1, 0, 0));
    tbl.push_back(mk(1, 'h12,  0, 0, 0, 1, 1, 'h11,  2, 0, 0));
    tbl.push_back(mk(1, 'h13,  0, 0, 0, 0, 1, 'h11,  2, 0, 0));
    tbl.push_back(mk(1, 'h13,  1, 0, 0, 0, 1, 'h12,  1, 0, 0));
    tbl.push_back(mk(1, 'h13,  1, 0, 0, 1, 1, 'h13,  1, 0, 0));
    tbl.push_back(mk(0, 0,     1, 0, 0, 1, 0, 'h13,  0, 0, 0));
    tbl.push_back(mk(1, 'h21,  0, 0, 0, 1, 1, 'h21,  1, 0, 0));
    tbl.push_back(mk(1, 'h22,  0, 0, 0, 1, 1, 'h21,  2, 0, 0));
    tbl.push_back(mk(1, 'h23,  0, 0, 1, 0, 0, 'h21,  0, 0, 1));
    tbl.push_back(mk(0, 0,     1, 0, 0, 1, 0, 'h21,  0, 0, 1));
    tbl.push_back(mk(1, 'h31,  0, 0, 0, 1, 1, 'h31,  1, 0, 1));
    tbl.push_back(mk(0, 0,     0, 1, 1, 0, 0, 'h31,  0, 1, 2));
    tbl.push_back(mk(1, 'h41,  1, 0, 0, 1, 1, 'h41,  1, 1, 2));
    for (int k = 1; k <= 5; k++) tbl.push_back(mk(1, 'h42, 1, 1, 0, 0, 1, 'h41, 1, 16'(1 + k), 2));
    tbl.push_back(mk(1, 'h42,  1, 0, 0, 1, 1, 'h42,  1, 6, 2));
    tbl.push_back(mk(0, 0,     1, 0, 0, 1, 0, 'h42,  0, 6, 2));
    #1 rst_n = 1'b0;
    #1;
    chk("reset.out_valid", 64'(a_ov), 0);
    chk("reset.in_ready", 64'(a_ir), 0);
    chk("reset.occupancy", 64'(a_occ), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    foreach (tbl[n]) begin
      @(negedge clk);
      a_v = tbl[n].v; a_d = tbl[n].d; a_or = tbl[n].o_r; a_st = tbl[n].st; a_fl = tbl[n].fl;
      #1 chk($sformatf("vec%0d.in_ready", n), 64'(a_ir), 64'(tbl[n].e_ir));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d.out_valid", n), 64'(a_ov), 64'(tbl[n].e_ov));
      chk($sformatf("vec%0d.out_ctrl", n), 64'(a_c), tbl[n].e_ov ? 64'(C) : 64'd0);
      chk($sformatf("vec%0d.out_data", n), 64'(a_q), 64'(tbl[n].e_d));
      chk($sformatf("vec%0d.occupancy", n), 64'(a_occ), 64'(tbl[n].e_occ));
      chk($sformatf("vec%0d.stall_cnt", n), 64'(a_sc), 64'(tbl[n].e_sc));
      chk($sformatf("vec%0d.flush_cnt", n), 64'(a_fc), 64'(tbl[n].e_fc));
    end
    // Fill main and skid, then pull reset a few ns after the edge
    @(negedge clk);
    a_v = 1; a_d = 'h55; a_or = 0; a_st = 0; a_fl = 0;
    @(posedge clk);
    @(posedge clk);
    #1 chk("prerst.occupancy", 64'(a_occ), 2);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst.out_valid", 64'(a_ov), 0);
    chk("async_rst.out_ctrl", 64'(a_c), 0);
    chk("async_rst.out_data", 64'(a_q), 0);
    chk("async_rst.occupancy", 64'(a_occ), 0);
    chk("async_rst.in_ready", 64'(a_ir), 0);
    chk("async_rst.stall_cnt", 64'(a_sc), 0);
    chk("async_rst.flush_cnt", 64'(a_fc), 0);
    @(negedge clk);
    a_v = 0;
    rst_n = 1'b1;
    #1 chk("post_rst.in_ready", 64'(a_ir), 1);
    @(posedge clk);
    #1 chk("post_rst.out_valid", 64'(a_ov), 0);
    b_step("b0", 1, 1, 1, 0, 1, 1, 1, 0);
    b_step("b1", 1, 2, 0, 0, 0, 1, 1, 0);
    b_step("b2", 1, 2, 1, 0, 1, 1, 2, 0);
    b_step("b3", 1, 3, 0, 0, 0, 1, 2, 0);
    @(negedge clk);
    b_or = 1;
    #1 chk("b_comb.ready_hi", 64'(b_ir), 1);
    b_or = 0;
    #1 chk("b_comb.ready_lo", 64'(b_ir), 0);
    for (int k = 1; k <= 7; k++)
      b_step($sformatf("b_stall%0d", k), 1, 3, 1, 1, 0, 1, 2, 2'(k > 3 ? 3 : k));
    b_step("b_drain", 0, 0, 1, 0, 1, 0, 2, 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
